aes_keysched_ctrl: RTL and testbench

Iterative AES-128 key-schedule controller for the 32-bit I/O encryption core. It accepts a 128-bit cipher key as four 32-bit words. It then sequences the single-round `aes_keyexp` datapath once per cycle through rounds 1..10 and stores all 11 round keys in an internal register file. The cipher round engine reads round keys from that file by index.

---
 rtl/aes_keysched_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_aes_keysched_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_keysched_ctrl.sv
// AES-128 key-schedule controller: loads a 128-bit key as four words, expands
// one round per cycle into an 11-entry round-key file, serves indexed reads.

module aes_keyexp (
  input  logic [3:0]   rnd,
  input  logic [127:0] prev_key,
  output logic [127:0] next_key
);

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (a^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r, s;
    r = 8'h01;
    s = a;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
             ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  logic [7:0]  rcon;
  logic [31:0] w0, w1, w2, w3, t;
  logic [31:0] n0, n1, n2, n3;

  always_comb begin
    rcon = 8'h00;
    unique case (rnd)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign w0 = prev_key[127:96];
  assign w1 = prev_key[95:64];
  assign w2 = prev_key[63:32];
  assign w3 = prev_key[31:0];

  assign t = {sbox(w3[23:16]), sbox(w3[15:8]),
              sbox(w3[7:0]),   sbox(w3[31:24])}
           ^ {rcon, 24'h000000};

  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key = {n0, n1, n2, n3};

endmodule

module aes_keysched_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  input  logic         rk_rd,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out,
  output logic         rk_out_valid,
  output logic         rk_err
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_EXPAND,
    S_READY
  } state_t;

  state_t state, state_n;

  logic [1:0]   cnt;
  logic [3:0]   rnd;
  logic [95:0]  asm_q;
  logic [127:0] prev_key;
  logic [127:0] next_key;
  logic [127:0] rk_file [0:10];
  logic         done_q;
  logic         accept;
  logic         last_word;
  logic         last_rnd;
  logic         rd_ok;

  aes_keyexp u_keyexp (
    .rnd      (rnd),
    .prev_key (prev_key),
    .next_key (next_key)
  );

  assign key_ready  = (state != S_EXPAND);
  assign busy       = (state == S_EXPAND);
  assign keys_valid = (state == S_READY);
  assign done       = done_q;

  assign accept    = key_valid & key_ready;
  assign last_word = accept & (cnt == 2'd3);
  assign last_rnd  = busy & (rnd == 4'd10);
  assign rd_ok     = keys_valid & (rk_idx <= 4'd10);

  always_ff @(posedge clk) begin
    if (rst) state <= S_LOAD;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_LOAD:   if (last_word) state_n = S_EXPAND;
      S_EXPAND: if (last_rnd)  state_n = S_READY;
      S_READY:  if (accept)    state_n = S_LOAD;
      default:  state_n = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 2'd0;
      rnd      <= 4'd0;
      asm_q    <= '0;
      prev_key <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= last_rnd;
      if (accept) begin
        asm_q <= {asm_q[63:0], key_in};
        cnt   <= cnt + 2'd1;
      end
      if (last_word) begin
        prev_key <= {asm_q, key_in};
        rnd      <= 4'd1;
      end else if (busy) begin
        prev_key <= next_key;
        rnd      <= last_rnd ? 4'd0 : rnd + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (last_word)
      rk_file[0] <= {asm_q, key_in};
    else if (busy)
      rk_file[rnd] <= next_key;
  end

  // Reads see the file before any same-cycle write
  always_ff @(posedge clk) begin
    if (rst) begin
      rk_out       <= '0;
      rk_out_valid <= 1'b0;
      rk_err       <= 1'b0;
    end else begin
      rk_out_valid <= rk_rd;
      rk_err       <= rk_rd & ~rd_ok;
      if (rk_rd)
        rk_out <= rd_ok ? rk_file[rd_ok ? rk_idx : 4'd0] : '0;
    end
  end

endmodule

// File: tb/tb_aes_keysched_ctrl.sv
// Randomized self-checking bench for aes_keysched_ctrl against a
// word-oriented FIPS-197 key-expansion model.

module tb_aes_keysched_ctrl;

  logic         clk;
  logic         rst;
  logic [31:0]  key_in;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic         rk_rd;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;
  logic         rk_out_valid;
  logic         rk_err;

  aes_keysched_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .key_in       (key_in),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .busy         (busy),
    .done         (done),
    .keys_valid   (keys_valid),
    .rk_rd        (rk_rd),
    .rk_idx       (rk_idx),
    .rk_out       (rk_out),
    .rk_out_valid (rk_out_valid),
    .rk_err       (rk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] exp_rk [11];
  bit           exp_kv;

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    logic [15:0] d;
    d = {a, a} << n;
    return d[15:8];
  endfunction

  // Table built by the multiply-by-3 / divide-by-3 generator walk
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int i = 0; i < 255; i++) begin
      p = p ^ xtime(p);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]],
            sbox_t[w[15:8]],  sbox_t[w[7:0]]};
  endfunction

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] exp_out(input logic [3:0] idx);
    return (exp_kv && idx <= 4'd10) ? exp_rk[idx] : 128'h0;
  endfunction

  task automatic chk_reset(input string tag);
    check({tag, "_flags"},
          {124'h0, key_ready, busy, done, keys_valid},
          128'h8);
    check({tag, "_rdflags"}, {126'h0, rk_out_valid, rk_err}, 128'h0);
    check({tag, "_rk_out"}, rk_out, 128'h0);
  endtask

  task automatic rd1(input string tag, input logic [3:0] idx,
                     input logic [127:0] exp, input bit exp_err);
    rk_rd  = 1'b1;
    rk_idx = idx;
    @(negedge clk);
    rk_rd = 1'b0;
    check({tag, "_v"}, {126'h0, rk_out_valid, rk_err},
          {126'h0, 1'b1, exp_err});
    check({tag, "_d"}, rk_out, exp);
  endtask

  task automatic rd_burst(input int n, input bit rand_idx);
    logic [3:0]   pidx;
    logic [127:0] last;
    bit           pend;
    pend = 1'b0;
    pidx = 4'd0;
    last = rk_out;
    for (int i = 0; i <= n; i++) begin
      if (pend) begin
        check("burst_v", {126'h0, rk_out_valid, rk_err},
              {126'h0, 1'b1, !(exp_kv && pidx <= 4'd10)});
        check("burst_d", rk_out, exp_out(pidx));
        last = exp_out(pidx);
      end
      if (i < n) begin
        pidx   = rand_idx ? 4'($urandom_range(0, 15)) : 4'(i);
        rk_rd  = 1'b1;
        rk_idx = pidx;
        pend   = 1'b1;
      end else begin
        rk_rd = 1'b0;
        pend  = 1'b0;
      end
      @(negedge clk);
    end
    check("rd_hold_v", {127'h0, rk_out_valid}, 128'h0);
    check("rd_hold_d", rk_out, last);
  endtask

  task automatic load_key(input logic [127:0] key, input int gap,
                          input bit stall, input bit rekey_rd,
                          input int rst_at);
    for (int w = 0; w < 4; w++) begin
      check("key_ready_ld", {127'h0, key_ready}, 128'h1);
      key_valid = 1'b1;
      key_in    = key[127-32*w -: 32];
      if (w == 0 && rekey_rd) begin
        rk_rd  = 1'b1;
        rk_idx = 4'd1;
      end
      @(negedge clk);
      key_valid = 1'b0;
      key_in    = $urandom;
      if (w == 0 && rekey_rd) begin
        rk_rd = 1'b0;
        check("rekey_kv", {127'h0, keys_valid}, 128'h0);
        check("rekey_old_v", {126'h0, rk_out_valid, rk_err}, 128'h2);
        check("rekey_old_d", rk_out, exp_rk[1]);
      end
      exp_kv = 1'b0;
      if (w < 3) repeat (gap) @(negedge clk);
    end
    for (int k = 1; k <= 13; k++) begin
      check($sformatf("timing_k%0d", k),
            {124'h0, busy, key_ready, done, keys_valid},
            {124'h0, k <= 10, k > 10, k == 11, k >= 11});
      if (k == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        chk_reset("rst_mid");
        rst = 1'b0;
        return;
      end
      key_valid = stall && k <= 10;
      key_in    = $urandom;
      @(negedge clk);
    end
    key_valid = 1'b0;
    model_expand(key);
    exp_kv = 1'b1;
  endtask

  initial begin
    logic [127:0] rk;
    build_sbox();
    for (int r = 0; r < 11; r++) exp_rk[r] = '0;
    exp_kv    = 1'b0;
    rst       = 1'b1;
    key_in    = '0;
    key_valid = 1'b0;
    rk_rd     = 1'b0;
    rk_idx    = '0;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    rd1("pre_load_rd", 4'd3, 128'h0, 1'b1);

    load_key(KEY_A, 0, 0, 0, 0);
    rd1("rk0", 4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0);
    rd1("rk1", 4'd1, 128'ha0fafe1788542cb123a339392a6c7605, 1'b0);
    rd1("rk10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0);
    rd_burst(11, 1'b0);
    rd1("bad11", 4'd11, 128'h0, 1'b1);
    rd1("bad15", 4'd15, 128'h0, 1'b1);
    rd_burst(20, 1'b1);

    load_key(KEY_A, 3, 1, 0, 0);
    rd1("gap_rk10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0);
    rd_burst(11, 1'b0);

    load_key(128'h0, 0, 0, 1, 0);
    rd1("zero_rk1", 4'd1, 128'h62636363626363636263636362636363, 1'b0);
    rd1("zero_rk10", 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, 1'b0);
    rd_burst(11, 1'b0);

    for (int n = 0; n < 3; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      load_key(rk, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 0, 0);
      rd_burst(16, 1'b1);
    end

    load_key(KEY_A, 0, 0, 0, 5);
    rd1("post_rst_rd", 4'd0, 128'h0, 1'b1);

    for (int w = 0; w < 2; w++) begin
      key_valid = 1'b1;
      key_in    = $urandom;
      @(negedge clk);
    end
    key_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk_reset("rst_partial");
    rst = 1'b0;
    @(negedge clk);

    rk = {$urandom, $urandom, $urandom, $urandom};
    load_key(rk, 1, 0, 0, 0);
    rd_burst(11, 1'b0);
    load_key(KEY_A, 0, 0, 0, 0);
    rd1("final_rk1", 4'd1, 128'ha0fafe1788542cb123a339392a6c7605, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
